// File: rtl/ps2_key_event_ctrl_if.sv
// Event-side handshake between the PS/2 key event controller and its consumer.
// master = controller (drives the FIFO head), slave = game logic.
interface ps2_key_event_ctrl_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             ev_valid;
    logic             ev_ready;
    logic [7:0]       ev_code;
    logic             ev_ext;
    logic             ev_break;
    logic [LVL_W-1:0] ev_level;
    logic             overflow;

    modport master (
        output ev_valid, ev_code, ev_ext, ev_break, ev_level, overflow,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_code, ev_ext, ev_break, ev_level, overflow,
        output ev_ready
    );
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// Turns PS/2 scan bytes into make/break events (E0/F0 prefix FSM with watchdog),
// queues them in a first-word-fall-through FIFO and tracks held movement keys.
module ps2_key_event_ctrl #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        byte_valid,
    input  logic [7:0]                  byte_data,
    ps2_key_event_ctrl_if.master        ev,
    output logic [3:0]                  dir_held
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, PRE_E0, PRE_F0, PRE_E0F0} state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    state_t           state_q, state_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       press_q, press_d;
    logic [3:0]       dir_q, dir_d;
    ev_t              mem_q [FIFO_DEPTH];

    logic emit, pop, full, push_ok, head_vld;
    ev_t  emit_ev, head;

    // Bytes that carry no key information (ACK, BAT, echo, resend, error, Pause lead-in).
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFE) ||
               (b == 8'hE1) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    // One-hot bit per movement source: [0]W [1]S [2]A [3]D [4]Up [5]Down [6]Left [7]Right.
    function automatic logic [7:0] key_mask(input logic [7:0] code, input logic ext);
        logic [7:0] m;
        m = 8'd0;
        if (!ext) begin
            case (code)
                8'h1D:   m[0] = 1'b1;
                8'h1B:   m[1] = 1'b1;
                8'h1C:   m[2] = 1'b1;
                8'h23:   m[3] = 1'b1;
                default: m = 8'd0;
            endcase
        end else begin
            case (code)
                8'h75:   m[4] = 1'b1;
                8'h72:   m[5] = 1'b1;
                8'h6B:   m[6] = 1'b1;
                8'h74:   m[7] = 1'b1;
                default: m = 8'd0;
            endcase
        end
        return m;
    endfunction

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        emit    = 1'b0;
        emit_ev = '0;
        if (byte_valid) begin
            wd_d = '0;
            case (state_q)
                IDLE: begin
                    if (byte_data == 8'hE0) begin
                        state_d = PRE_E0;
                    end else if (byte_data == 8'hF0) begin
                        state_d = PRE_F0;
                    end else if (!is_ignored(byte_data)) begin
                        emit    = 1'b1;
                        emit_ev = '{code: byte_data, ext: 1'b0, brk: 1'b0};
                    end
                end
                PRE_E0: begin
                    if (byte_data == 8'hF0) begin
                        state_d = PRE_E0F0;
                    end else if (byte_data != 8'hE0) begin
                        emit    = 1'b1;
                        emit_ev = '{code: byte_data, ext: 1'b1, brk: 1'b0};
                        state_d = IDLE;
                    end
                end
                PRE_F0: begin
                    emit    = 1'b1;
                    emit_ev = '{code: byte_data, ext: 1'b0, brk: 1'b1};
                    state_d = IDLE;
                end
                default: begin
                    emit    = 1'b1;
                    emit_ev = '{code: byte_data, ext: 1'b1, brk: 1'b1};
                    state_d = IDLE;
                end
            endcase
        end else if (state_q == IDLE) begin
            wd_d = '0;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            // Stalled prefix: drop it silently.
            wd_d    = '0;
            state_d = IDLE;
        end else begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_comb begin
        head_vld = (cnt_q != '0);
        head     = mem_q[rd_ptr_q];
        pop      = head_vld & ev.ev_ready;
        full     = (cnt_q == LVL_W'(FIFO_DEPTH));
        push_ok  = emit & (~full | pop);
        ovf_d    = emit & full & ~pop;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok && !pop) begin
            cnt_d = cnt_q + LVL_W'(1);
        end else if (!push_ok && pop) begin
            cnt_d = cnt_q - LVL_W'(1);
        end
        // Held keys follow every emitted event, even one the FIFO had to drop.
        press_d = press_q;
        if (emit) begin
            if (emit_ev.brk) press_d = press_q & ~key_mask(emit_ev.code, emit_ev.ext);
            else             press_d = press_q |  key_mask(emit_ev.code, emit_ev.ext);
        end
        dir_d = {press_d[0] | press_d[4], press_d[1] | press_d[5],
                 press_d[2] | press_d[6], press_d[3] | press_d[7]};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            wd_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            press_q  <= 8'd0;
            dir_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            wd_q     <= wd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            press_q  <= press_d;
            dir_q    <= dir_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) mem_q[wr_ptr_q] <= emit_ev;
    end

    // Head fields are forced to zero when empty so storage contents never leak out.
    assign ev.ev_valid = head_vld;
    assign ev.ev_code  = head_vld ? head.code : 8'd0;
    assign ev.ev_ext   = head_vld & head.ext;
    assign ev.ev_break = head_vld & head.brk;
    assign ev.ev_level = cnt_q;
    assign ev.overflow = ovf_q;
    assign dir_held    = dir_q;
endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl: a queue-based event model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_ps2_key_event_ctrl;
    localparam int FD = 8;
    localparam int TO = 20;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'd0;
    logic [3:0] dir_held;

    ps2_key_event_ctrl_if #(.FIFO_DEPTH(FD)) evif();

    ps2_key_event_ctrl #(.FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .ev         (evif),
        .dir_held   (dir_held)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0] code;
        bit         ext;
        bit         brk;
    } ev_s;

    ev_s      mq[$];
    bit       m_ext, m_brk, m_ovf;
    int       m_idle;
    bit [7:0] m_press;
    int       checks = 0;
    int       errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int key_idx(input logic [7:0] c, input bit e);
        logic [7:0] plain[4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
        logic [7:0] extk[4]  = '{8'h75, 8'h72, 8'h6B, 8'h74};
        for (int i = 0; i < 4; i++) begin
            if (!e && c == plain[i]) return i;
            if (e && c == extk[i]) return i + 4;
        end
        return -1;
    endfunction

    // Model: prefix flags and a queue of finished events.
    always @(posedge clk_in or posedge rst_in) begin
        bit  pop, have;
        ev_s e;
        int  k;
        if (rst_in) begin
            mq.delete();
            m_ext = 0; m_brk = 0; m_ovf = 0; m_idle = 0; m_press = '0;
        end else begin
            pop  = (mq.size() != 0) && evif.ev_ready;
            have = 0;
            e    = '{8'h00, 0, 0};
            m_ovf = 0;
            if (byte_valid) begin
                m_idle = 0;
                if (m_brk) begin
                    e = '{byte_data, m_ext, 1}; have = 1; m_ext = 0; m_brk = 0;
                end else if (m_ext) begin
                    if (byte_data == 8'hF0) m_brk = 1;
                    else if (byte_data != 8'hE0) begin
                        e = '{byte_data, 1, 0}; have = 1; m_ext = 0;
                    end
                end else if (byte_data == 8'hE0) m_ext = 1;
                else if (byte_data == 8'hF0) m_brk = 1;
                else if (!(byte_data inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hE1, 8'h00, 8'hFF})) begin
                    e = '{byte_data, 0, 0}; have = 1;
                end
            end else if (m_ext || m_brk) begin
                m_idle++;
                if (m_idle == TO) begin m_ext = 0; m_brk = 0; m_idle = 0; end
            end
            if (pop) void'(mq.pop_front());
            if (have) begin
                k = key_idx(e.code, e.ext);
                if (k >= 0) m_press[k] = !e.brk;
                if (mq.size() < FD) mq.push_back(e);
                else m_ovf = 1;
            end
        end
    end

    always @(negedge clk_in) begin
        check("ev_valid", evif.ev_valid, mq.size() != 0);
        check("ev_level", evif.ev_level, mq.size());
        check("overflow", evif.overflow, m_ovf);
        check("dir_held", dir_held, {m_press[0] | m_press[4], m_press[1] | m_press[5],
                                     m_press[2] | m_press[6], m_press[3] | m_press[7]});
        if (mq.size() != 0) begin
            check("ev_code", evif.ev_code, mq[0].code);
            check("ev_ext", evif.ev_ext, mq[0].ext);
            check("ev_break", evif.ev_break, mq[0].brk);
        end else begin
            check("empty_head", {evif.ev_code, evif.ev_ext, evif.ev_break}, 0);
        end
    end

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk_in); #1;
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    initial begin
        evif.ev_ready = 1'b0;
        repeat (3) @(negedge clk_in);
        check("lit_rst_valid", evif.ev_valid, 0);
        check("lit_rst_level", evif.ev_level, 0);
        check("lit_rst_dir", dir_held, 4'b0000);
        rst_in = 1'b0;
        idle(1);

        // W press/release, with ignored bytes first
        evif.ev_ready = 1'b1;
        send(8'hFA); send(8'hAA);
        idle(1);
        check("lit_ignored_level", evif.ev_level, 0);
        send(8'h1D);
        @(negedge clk_in);
        check("lit_w_make", {evif.ev_valid, evif.ev_code, evif.ev_ext, evif.ev_break}, {1'b1, 8'h1D, 2'b00});
        check("lit_w_dir", dir_held, 4'b1000);
        send(8'hF0); send(8'h1D);
        @(negedge clk_in);
        check("lit_w_break", {evif.ev_code, evif.ev_ext, evif.ev_break}, {8'h1D, 2'b01});
        check("lit_w_dir0", dir_held, 4'b0000);

        // Extended Up press/release
        send(8'hE0); send(8'h75);
        @(negedge clk_in);
        check("lit_up_make", {evif.ev_code, evif.ev_ext, evif.ev_break}, {8'h75, 2'b10});
        check("lit_up_dir", dir_held, 4'b1000);
        send(8'hE0); send(8'hF0); send(8'h75);
        @(negedge clk_in);
        check("lit_up_break", {evif.ev_code, evif.ev_ext, evif.ev_break}, {8'h75, 2'b11});
        check("lit_up_dir0", dir_held, 4'b0000);
        idle(2);

        // Fill FIFO and overflow once
        evif.ev_ready = 1'b0;
        repeat (9) send(8'h15);
        @(negedge clk_in);
        check("lit_full_level", evif.ev_level, 8);
        check("lit_ovf_pulse", evif.overflow, 1);
        idle(2);
        // Push and pop together while full
        evif.ev_ready = 1'b1;
        send(8'h2B);
        evif.ev_ready = 1'b0;
        @(negedge clk_in);
        check("lit_full_pushpop_level", evif.ev_level, 8);
        check("lit_full_pushpop_ovf", evif.overflow, 0);
        evif.ev_ready = 1'b1;
        idle(10);
        check("lit_drained", evif.ev_level, 0);

        // Watchdog: abandoned E0, then a plain A
        send(8'hE0);
        idle(TO);
        send(8'h1C);
        @(negedge clk_in);
        check("lit_to_code", {evif.ev_code, evif.ev_ext, evif.ev_break}, {8'h1C, 2'b00});
        check("lit_to_dir", dir_held, 4'b0010);
        send(8'hF0); send(8'h1C);
        // Byte arriving on the timeout cycle is still treated as extended
        send(8'hE0);
        idle(TO - 1);
        send(8'h72);
        @(negedge clk_in);
        check("lit_bytewins", {evif.ev_code, evif.ev_ext, evif.ev_break}, {8'h72, 2'b10});
        send(8'hE0); send(8'hF0); send(8'h72);
        idle(2);

        // Hold W and Up, release W only
        send(8'h1D); send(8'hE0); send(8'h75);
        send(8'hF0); send(8'h1D);
        @(negedge clk_in);
        check("lit_up_still_held", dir_held, 4'b1000);

        // Reset during an E0 F0 sequence
        send(8'hE0); send(8'hF0);
        #2 rst_in = 1'b1;
        @(negedge clk_in);
        check("lit_midrst_out", {evif.ev_valid, evif.ev_level, evif.overflow, dir_held}, 0);
        rst_in = 1'b0;
        idle(1);
        send(8'h23);
        @(negedge clk_in);
        check("lit_after_rst", {evif.ev_code, evif.ev_ext, evif.ev_break}, {8'h23, 2'b00});
        check("lit_after_rst_dir", dir_held, 4'b0001);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
